// File: rtl/sha256_block_core_if.sv
// rtl/sha256_block_core_if.sv - SHA-256 core request/response bus between a hash client and the core
interface sha256_block_core_if;
  logic         sha_reset_n;
  logic         sha_init;
  logic [511:0] sha_block;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic         sha_digest_valid;

  modport master (
    output sha_reset_n, sha_init, sha_block,
    input  sha_ready, sha_digest, sha_digest_valid
  );

  modport slave (
    input  sha_reset_n, sha_init, sha_block,
    output sha_ready, sha_digest, sha_digest_valid
  );
endinterface

// File: rtl/sha256_block_core.sv
// rtl/sha256_block_core.sv - single-block SHA-256 compression engine behind the shared SHA bus
// Define SHA256_DOUBLE_ROUND_EN for two rounds per cycle (latency 33 instead of 65).
module sha256_block_core #(
  parameter logic [255:0] HASH_INIT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic              clk,
  input  logic              reset,
  sha256_block_core_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef SHA256_DOUBLE_ROUND_EN
  localparam logic [5:0] CNT_STEP = 6'd2;
  localparam logic [5:0] CNT_LAST = 6'd62;
`else
  localparam logic [5:0] CNT_STEP = 6'd1;
  localparam logic [5:0] CNT_LAST = 6'd63;
`endif

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [255:0]       work;
  logic [0:15][31:0]  win;
  logic [255:0]       digest_q;
  logic               valid_q;
  logic [255:0]       work_nxt;
  logic [255:0]       final_sum;
  logic [31:0]        w_new0;
  logic [31:0]        w_new1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sched(input logic [31:0] w2, input logic [31:0] w7,
                                         input logic [31:0] w15, input logic [31:0] w16);
    logic [31:0] s0;
    logic [31:0] s1;
    s0 = rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3);
    s1 = rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10);
    return s1 + w7 + s0 + w16;
  endfunction

  function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // win[0] is W[t]; the two candidate new words are W[t+16] and W[t+17]
  always_comb begin
    w_new0 = sched(win[14], win[9], win[1], win[0]);
    w_new1 = sched(win[15], win[10], win[2], win[1]);
`ifdef SHA256_DOUBLE_ROUND_EN
    work_nxt = round_step(round_step(work, K[cnt], win[0]), K[cnt + 6'd1], win[1]);
`else
    work_nxt = round_step(work, K[cnt], win[0]);
`endif
    final_sum = '0;
    for (int i = 0; i < 8; i++)
      final_sum[255 - 32*i -: 32] = HASH_INIT[255 - 32*i -: 32] + work[255 - 32*i -: 32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      win      <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
    end else if (!bus.sha_reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      work     <= '0;
      win      <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.sha_init) begin
            win     <= bus.sha_block;
            work    <= HASH_INIT;
            cnt     <= '0;
            valid_q <= 1'b0;
            state   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= work_nxt;
`ifdef SHA256_DOUBLE_ROUND_EN
          win  <= {win[2:15], w_new0, w_new1};
`else
          win  <= {win[1:15], w_new0};
`endif
          cnt  <= cnt + CNT_STEP;
          if (cnt == CNT_LAST)
            state <= ST_FINAL;
        end
        default: begin
          digest_q <= final_sum;
          valid_q  <= 1'b1;
          state    <= ST_DONE;
        end
      endcase
    end
  end

`ifndef SHA256_DOUBLE_ROUND_EN
  logic unused_w_new1;
  assign unused_w_new1 = ^w_new1;
`endif

  assign bus.sha_ready        = (state == ST_IDLE) || (state == ST_DONE);
  assign bus.sha_digest       = digest_q;
  assign bus.sha_digest_valid = valid_q;

endmodule

// File: tb/tb_sha256_block_core.sv
// tb/tb_sha256_block_core.sv - self-checking bench for sha256_block_core
// Latency expectation follows SHA256_DOUBLE_ROUND_EN when that macro is defined.
module tb_sha256_block_core;

`ifdef SHA256_DOUBLE_ROUND_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [511:0] blk;
    logic [255:0] dig;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [255:0] sb [$];

  sha256_block_core_if bus ();

  sha256_block_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_digest(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = IV[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + IV[255 - 32*i -: 32];
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [511:0] blk, input logic [255:0] exp, input bit push);
    @(negedge clk);
    bus.sha_block = blk;
    bus.sha_init  = 1'b1;
    @(posedge clk);
    #1;
    bus.sha_init  = 1'b0;
    bus.sha_block = {16{$urandom()}};
    if (push) sb.push_back(exp);
    check("busy_ready", {255'b0, bus.sha_ready}, 256'd0);
    check("busy_valid", {255'b0, bus.sha_digest_valid}, 256'd0);
  endtask

  task automatic wait_done(input string name, input int from);
    int cyc;
    logic [255:0] exp;
    cyc = from;
    while (bus.sha_digest_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, 256'(cyc), 256'(LAT));
    check({name, "_ready"}, {255'b0, bus.sha_ready}, 256'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    check({name, "_digest"}, bus.sha_digest, exp);
  endtask

  task automatic soft_clear(input string name);
    @(negedge clk);
    bus.sha_reset_n = 1'b0;
    @(posedge clk);
    #1;
    bus.sha_reset_n = 1'b1;
    check({name, "_clr_ready"}, {255'b0, bus.sha_ready}, 256'd1);
    check({name, "_clr_valid"}, {255'b0, bus.sha_digest_valid}, 256'd0);
    check({name, "_clr_digest"}, bus.sha_digest, 256'd0);
  endtask

  initial begin
    vec_t vt [4];
    total = 0;
    bad   = 0;
    vt[0].blk = BLK_ABC;   vt[0].dig = DIG_ABC;
    vt[1].blk = BLK_EMPTY; vt[1].dig = DIG_EMPTY;
    for (int i = 2; i < 4; i++) begin
      vt[i].blk = {16{$urandom()}} ^ {$urandom(), 448'h0, $urandom()};
      vt[i].dig = ref_digest(vt[i].blk);
    end

    bus.sha_reset_n = 1'b1;
    bus.sha_init    = 1'b0;
    bus.sha_block   = '0;
    reset = 1'b1;
    #2;
    check("rst_ready", {255'b0, bus.sha_ready}, 256'd1);
    check("rst_valid", {255'b0, bus.sha_digest_valid}, 256'd0);
    check("rst_digest", bus.sha_digest, 256'd0);
    #20;
    reset = 1'b0;

    // client loop: each request only after a cleared idle cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hs_ready", {255'b0, bus.sha_ready}, 256'd1);
      check("hs_valid", {255'b0, bus.sha_digest_valid}, 256'd0);
      start(vt[i].blk, vt[i].dig, 1'b1);
      wait_done($sformatf("vec%0d", i), 0);
      soft_clear($sformatf("vec%0d", i));
    end

    // new request straight from DONE drops valid on the next cycle
    start(BLK_ABC, DIG_ABC, 1'b1);
    wait_done("done_a", 0);
    start(BLK_EMPTY, DIG_EMPTY, 1'b1);
    wait_done("done_b", 0);
    soft_clear("done");

    // init while busy is ignored
    start(BLK_ABC, DIG_ABC, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.sha_block = BLK_EMPTY;
    bus.sha_init  = 1'b1;
    @(posedge clk);
    #1;
    bus.sha_init = 1'b0;
    wait_done("busy_init", 10);
    soft_clear("busy_init");

    // soft clear at T+30, then reissue
    start(BLK_ABC, '0, 1'b0);
    repeat (28) @(posedge clk);
    soft_clear("mid");
    start(BLK_ABC, DIG_ABC, 1'b1);
    wait_done("mid_reissue", 0);

    // async reset mid-ROUND while the old digest is still held
    start(BLK_EMPTY, '0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_ready", {255'b0, bus.sha_ready}, 256'd1);
    check("async_valid", {255'b0, bus.sha_digest_valid}, 256'd0);
    check("async_digest", bus.sha_digest, 256'd0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("async_idle_valid", {255'b0, bus.sha_digest_valid}, 256'd0);
    start(BLK_ABC, DIG_ABC, 1'b1);
    wait_done("after_async", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
